// File: rtl/global_params.sv
// Router-wide parameters and shared types for the diagonal-mesh router.
package global_params;

  localparam int unsigned FLIT_WIDTH = 32;
  localparam int unsigned N_PORTS    = 9;

  typedef enum logic [3:0] {
    PORT_N  = 4'd0,
    PORT_E  = 4'd1,
    PORT_S  = 4'd2,
    PORT_W  = 4'd3,
    PORT_L  = 4'd4,
    PORT_NE = 4'd5,
    PORT_NW = 4'd6,
    PORT_SE = 4'd7,
    PORT_SW = 4'd8
  } port_e;

  typedef logic [$clog2(N_PORTS)-1:0] port_idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req searching ptr, ptr+1, ... with wrap.
module rr_picker #(
  parameter int unsigned N_PORTS = global_params::N_PORTS,
  localparam int unsigned IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      winner
);

  localparam logic [IW-1:0] LAST = IW'(N_PORTS - 1);

  logic [IW-1:0] cand;

  // Walk every position once starting at ptr; the first hit is latched by found.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = ptr;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == LAST) ? '0 : cand + IW'(1);
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Output-port arbiter with wormhole lock and combinational flit mux behind a valid/ready link.
module port_arbiter
  import global_params::*;
#(
  parameter int unsigned N_PORTS    = global_params::N_PORTS,
  parameter int unsigned FLIT_WIDTH = global_params::FLIT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_PORTS-1:0]                  req,
  input  logic [N_PORTS-1:0]                  tail,
  input  logic [N_PORTS-1:0][FLIT_WIDTH-1:0]  in_flit,
  output logic [N_PORTS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]               out_flit,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_PORTS-1:0]                  grant,
  output logic                                locked
);

  localparam int unsigned   IW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_PORTS - 1);

  arb_state_e    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] winner;
  logic          found;
  logic          xfer;

  function automatic logic [N_PORTS-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  rr_picker #(
    .N_PORTS(N_PORTS)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .winner(winner)
  );

  // Reset is folded into the handshake so nothing is consumed on the edge that drops the lock.
  always_comb begin
    out_valid = (state == ARB_LOCKED) && req[sel] && !rst;
    out_flit  = out_valid ? in_flit[sel] : '0;
    in_ready  = '0;
    if (out_valid) begin
      in_ready[sel] = out_ready;
    end
    xfer = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      ptr    <= '0;
      sel    <= '0;
      grant  <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state  <= ARB_LOCKED;
            sel    <= winner;
            grant  <= onehot(winner);
            locked <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          // Only the owner's tail releases the worm; the pointer moves past it for fairness.
          if (xfer && tail[sel]) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            locked <= 1'b0;
            ptr    <= (sel == LAST) ? '0 : sel + IW'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter against a packet-level reference model.
module tb_port_arbiter;
  import global_params::*;

  localparam int NP = 9;
  localparam int FW = FLIT_WIDTH;
  localparam int VW = 2 * NP + 2 + FW;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NP-1:0]             req;
  logic [NP-1:0]             tail;
  logic [NP-1:0][FW-1:0]     in_flit;
  logic [NP-1:0]             in_ready;
  logic [FW-1:0]             out_flit;
  logic                      out_valid;
  logic                      out_ready;
  logic [NP-1:0]             grant;
  logic                      locked;
  logic [VW-1:0]             act_vec;

  port_arbiter #(
    .N_PORTS   (NP),
    .FLIT_WIDTH(FW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .tail     (tail),
    .in_flit  (in_flit),
    .in_ready (in_ready),
    .out_flit (out_flit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant    (grant),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  assign act_vec = {grant, locked, out_valid, in_ready, out_flit};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: who owns the output and where the priority pointer sits.
  bit m_locked = 1'b0;
  int m_sel    = 0;
  int m_ptr    = 0;

  logic          exp_valid;
  logic [FW-1:0] exp_flit;
  logic [NP-1:0] exp_ready;
  logic [NP-1:0] exp_grant;
  logic [VW-1:0] exp_vec;

  int            rem [NP];
  logic [FW-1:0] dat [NP];

  function automatic void predict();
    logic [NP-1:0] one;
    one       = 1;
    exp_valid = m_locked && req[m_sel] && !rst;
    exp_flit  = exp_valid ? in_flit[m_sel] : '0;
    exp_ready = (exp_valid && out_ready) ? (one << m_sel) : '0;
    exp_grant = m_locked ? (one << m_sel) : '0;
    exp_vec   = {exp_grant, m_locked, exp_valid, exp_ready, exp_flit};
  endfunction

  task automatic settle();
    @(negedge clk);
    predict();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_locked = 1'b0;
      m_sel    = 0;
      m_ptr    = 0;
    end else if (!m_locked) begin
      for (int k = 0; k < NP; k++) begin
        int idx;
        idx = (m_ptr + k) % NP;
        if (req[idx]) begin
          m_locked = 1'b1;
          m_sel    = idx;
          break;
        end
      end
    end else if (req[m_sel] && out_ready && tail[m_sel]) begin
      m_locked = 1'b0;
      m_ptr    = (m_sel + 1) % NP;
    end
    cyc++;
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b1; req = '0; tail = '0; out_ready = 1'b1; in_flit = '0;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; tail = '0; out_ready = 1'b1; in_flit = '0;
    for (int c = 0; c < 2; c++) begin
      settle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      advance();
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (act_vec !== exp_vec || act_vec !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", cyc, act_vec);
      end
      advance();
    end
  endtask

  task automatic test_single();
    logic [FW-1:0] d [3];
    for (int f = 0; f < 3; f++) d[f] = $urandom;
    req = '0; tail = '0; in_flit = '0; out_ready = 1'b1;
    req[4] = 1'b1; in_flit[4] = d[0];
    settle();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL single_arb cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
    end
    advance();
    for (int f = 0; f < 3; f++) begin
      in_flit[4] = d[f];
      tail[4]    = (f == 2);
      settle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL single_vec cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      total++;
      if (grant !== 9'h010 || out_flit !== d[f] || in_ready !== 9'h010) begin
        bad++;
        $display("FAIL single_flit f=%0d grant=%h flit=%h rdy=%h exp grant=010 flit=%h rdy=010",
                 f, grant, out_flit, in_ready, d[f]);
      end
      advance();
    end
    req = '0; tail = '0;
    settle();
    total++;
    if (locked !== 1'b0 || dut.ptr !== 4'd5 || act_vec !== exp_vec) begin
      bad++;
      $display("FAIL single_done locked=%b ptr=%0d exp locked=0 ptr=5", locked, dut.ptr);
    end
    advance();
  endtask

  task automatic test_fairness();
    logic [NP-1:0] one;
    logic [NP-1:0] eg;
    one = 1;
    reset_cycle();
    req = '1; tail = '1; out_ready = 1'b1;
    for (int i = 0; i < NP; i++) in_flit[i] = 32'hA000_0000 | i;
    for (int c = 0; c < 20; c++) begin
      settle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL fair_vec cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      eg = (c % 2 == 1) ? (one << ((c / 2) % NP)) : '0;
      total++;
      if (grant !== eg || locked !== (c % 2 == 1)) begin
        bad++;
        $display("FAIL fair_seq c=%0d grant=%h locked=%b exp grant=%h", c, grant, locked, eg);
      end
      advance();
    end
  endtask

  task automatic test_lock_hold();
    logic [NP-1:0] t_req  [8] = '{9'h004, 9'h004, 9'h080, 9'h080, 9'h084, 9'h080, 9'h080, 9'h000};
    logic [NP-1:0] t_tail [8] = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h004, 9'h000, 9'h080, 9'h000};
    logic [NP-1:0] t_gnt  [8] = '{9'h000, 9'h004, 9'h004, 9'h004, 9'h004, 9'h000, 9'h080, 9'h000};
    bit            t_val  [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
    reset_cycle();
    in_flit[2] = $urandom; in_flit[7] = $urandom; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req = t_req[c]; tail = t_tail[c];
      settle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL hold_vec c=%0d got=%h exp=%h", c, act_vec, exp_vec);
      end
      total++;
      if (grant !== t_gnt[c] || out_valid !== t_val[c]) begin
        bad++;
        $display("FAIL hold_seq c=%0d grant=%h valid=%b exp grant=%h valid=%b",
                 c, grant, out_valid, t_gnt[c], t_val[c]);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] d [3];
    for (int f = 0; f < 3; f++) d[f] = $urandom;
    reset_cycle();
    req = 9'h008; tail = '0; out_ready = 1'b1; in_flit[3] = d[0];
    for (int c = 0; c < 9; c++) begin
      in_flit[3] = (c <= 1) ? d[0] : (c <= 6) ? d[1] : d[2];
      tail[3]    = (c == 7);
      out_ready  = !(c >= 2 && c <= 5);
      req        = (c == 8) ? 9'h000 : 9'h008;
      settle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL bp_vec c=%0d got=%h exp=%h", c, act_vec, exp_vec);
      end
      if (c >= 2 && c <= 5) begin
        total++;
        if (in_ready !== '0 || out_valid !== 1'b1 || out_flit !== d[1]) begin
          bad++;
          $display("FAIL bp_stall c=%0d rdy=%h valid=%b flit=%h exp rdy=0 valid=1 flit=%h",
                   c, in_ready, out_valid, out_flit, d[1]);
        end
      end
      if (c == 6) begin
        total++;
        if (in_ready !== 9'h008) begin
          bad++;
          $display("FAIL bp_resume rdy=%h exp=008", in_ready);
        end
      end
      if (c == 8) begin
        total++;
        if (locked !== 1'b0) begin
          bad++;
          $display("FAIL bp_done locked=%b exp=0", locked);
        end
      end
      advance();
    end
  endtask

  task automatic test_wrap_reset();
    logic [NP-1:0] t_req  [6] = '{9'h040, 9'h040, 9'h000, 9'h100, 9'h100, 9'h000};
    logic [3:0]    t_ptr  [6] = '{4'd0, 4'd0, 4'd7, 4'd7, 4'd7, 4'd0};
    reset_cycle();
    out_ready = 1'b1; in_flit[6] = $urandom; in_flit[8] = $urandom; in_flit[0] = $urandom;
    for (int c = 0; c < 6; c++) begin
      req = t_req[c]; tail = t_req[c];
      settle();
      total++;
      if (act_vec !== exp_vec || dut.ptr !== t_ptr[c]) begin
        bad++;
        $display("FAIL wrap c=%0d got=%h ptr=%0d exp=%h ptr=%0d", c, act_vec, dut.ptr, exp_vec, t_ptr[c]);
      end
      advance();
    end
    req = 9'h001; tail = '0;
    for (int c = 0; c < 2; c++) begin
      settle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL lock0 c=%0d got=%h exp=%h", c, act_vec, exp_vec);
      end
      advance();
    end
    rst = 1'b1;
    settle();
    total++;
    if (in_ready !== '0 || out_valid !== 1'b0 || act_vec !== exp_vec) begin
      bad++;
      $display("FAIL rst_mid rdy=%h valid=%b exp rdy=0 valid=0", in_ready, out_valid);
    end
    advance();
    rst = 1'b0; req = '0;
    settle();
    total++;
    if (act_vec !== '0 || dut.ptr !== 4'd0 || dut.sel !== 4'd0) begin
      bad++;
      $display("FAIL rst_after got=%h ptr=%0d sel=%0d exp=0", act_vec, dut.ptr, dut.sel);
    end
    advance();
  endtask

  task automatic test_random();
    reset_cycle();
    for (int i = 0; i < NP; i++) begin
      rem[i] = 0;
      dat[i] = '0;
    end
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NP; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i] = $urandom_range(1, 4);
          dat[i] = $urandom;
        end
        req[i]     = (rem[i] != 0) && ($urandom_range(0, 7) != 0);
        tail[i]    = (rem[i] == 1);
        in_flit[i] = (rem[i] != 0) ? dat[i] : FW'($urandom);
      end
      settle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL rand n=%0d got=%h exp=%h", n, act_vec, exp_vec);
      end
      for (int i = 0; i < NP; i++) begin
        if (exp_ready[i]) begin
          rem[i]--;
          dat[i] = $urandom;
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock_hold();
    test_backpressure();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
